// File: rtl/pmod_bt2_pkg.sv
// Shared definitions for the PMOD BT2 UART link (device and host sides).
// Holds the UART FSM state encoding, frame constants and the baud divider helper.
package pmod_bt2_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBit   = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned UartDataBits = 8;
  localparam int unsigned UartStopBits = 1;

  // Integer clock cycles per bit; callers must keep the result >= 4.
  function automatic int unsigned clks_per_baud(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/bt2_byte_fifo.sv
// Synchronous byte FIFO for the BT2 receive path.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (empties the FIFO)
//   push_i   write data_i (taken when not full, or when full with a same-cycle pop)
//   data_i   byte to write
//   pop_i    remove head entry (ignored when empty)
//   data_o   head entry, stable until popped
//   full_o   all entries occupied
//   empty_o  no entries
//   count_o  current fill level
module bt2_byte_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullLevel = CntW'(Depth);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == FullLevel);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop at full frees the slot the simultaneous push lands in.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty/full come from count_q only.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pmod_bt2_device.sv
// Device-side PMOD BT2 emulation: looks like the BT2 module to a host UART (8N1, LSB first).
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   RXD / TXD             serial in from host / serial out to host (idle high)
//   CTS                   host clear-to-send, active low (gates TX accept only)
//   RTS                   device ready-to-receive, active low (high when RX FIFO nearly full)
//   STS                   registered copy of connected
//   BT_RST_N              host-driven module reset, active low
//   connected             local connection flag
//   tx_data/valid/ready   byte transmit handshake
//   rx_data/valid/ready   RX FIFO head and pop handshake
//   frame_err             1-cycle pulse, stop bit low, byte dropped
//   overrun               sticky, byte dropped because FIFO full
module pmod_bt2_device
  import pmod_bt2_pkg::*;
#(
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic       TXD,
  input  logic       CTS,
  output logic       RTS,
  output logic       STS,
  input  logic       BT_RST_N,
  input  logic       connected,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned ClksPerBaud = clks_per_baud(CLK_FREQ, BAUD);
  localparam int unsigned CntW        = $clog2(ClksPerBaud) + 1;
  localparam int unsigned FifoCntW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CntW-1:0]     BaudReload = CntW'(ClksPerBaud - 1);
  localparam logic [CntW-1:0]     HalfReload = CntW'(ClksPerBaud / 2 - 1);
  localparam logic [2:0]          LastBit    = 3'(UartDataBits - 1);
  localparam logic [FifoCntW-1:0] RtsLevel   = FifoCntW'(FIFO_DEPTH - 1);

  // Synchronizers; BT_RST_N resets low so local reset outlasts RST by the sync depth.
  logic [1:0] rxd_sync_q, cts_sync_q, bt_rst_sync_q;
  logic       rxd_prev_q;
  logic       rxd_s, cts_s, bt_rst_n_s, local_rst;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_sync_q    <= 2'b11;
      cts_sync_q    <= 2'b11;
      bt_rst_sync_q <= 2'b00;
      rxd_prev_q    <= 1'b1;
    end else begin
      rxd_sync_q    <= {rxd_sync_q[0], RXD};
      cts_sync_q    <= {cts_sync_q[0], CTS};
      bt_rst_sync_q <= {bt_rst_sync_q[0], BT_RST_N};
      rxd_prev_q    <= rxd_sync_q[1];
    end
  end

  assign rxd_s      = rxd_sync_q[1];
  assign cts_s      = cts_sync_q[1];
  assign bt_rst_n_s = bt_rst_sync_q[1];
  assign local_rst  = RST | ~bt_rst_n_s;

  // ---------------- TX ----------------
  uart_state_e     tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;

  assign tx_ready = (tx_state_q == StIdle) && !cts_s && !local_rst;
  assign TXD      = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (tx_valid && tx_ready) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = BaudReload;
          tx_state_d = StStart;
          txd_d      = 1'b0;
        end
      end
      StStart: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = StBit;
          tx_cnt_d   = BaudReload;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CntW'(1);
        end
      end
      StBit: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BaudReload;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == LastBit) begin
            tx_state_d = StStop;
            txd_d      = 1'b1;
          end else begin
            txd_d = tx_shift_q[tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (tx_cnt_q == '0) tx_state_d = StIdle;
        else                tx_cnt_d   = tx_cnt_q - CntW'(1);
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (local_rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- RX ----------------
  uart_state_e         rx_state_q, rx_state_d;
  logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FifoCntW-1:0] fifo_count;

  assign rx_valid  = !fifo_empty;
  assign fifo_pop  = rx_ready && rx_valid;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    fifo_push   = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        // Falling edge only, so a line held low after a bad frame cannot re-trigger.
        if (!rxd_s && rxd_prev_q) begin
          rx_state_d = StStart;
          rx_cnt_d   = HalfReload;
        end
      end
      StStart: begin
        if (rx_cnt_q == '0) begin
          if (rxd_s) begin
            rx_state_d = StIdle;
          end else begin
            rx_state_d = StBit;
            rx_cnt_d   = BaudReload;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      StBit: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_cnt_d   = BaudReload;
          if (rx_bit_q == LastBit) rx_state_d = StStop;
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = StIdle;
          if (rxd_s) begin
            if (fifo_full && !fifo_pop) overrun_d = 1'b1;
            else                        fifo_push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (local_rst) begin
      rx_state_q  <= StIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  bt2_byte_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i  (CLK),
    .rst_i  (local_rst),
    .push_i (fifo_push),
    .data_i (rx_shift_q),
    .pop_i  (fifo_pop),
    .data_o (rx_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // ---------------- Status ----------------
  logic rts_q, rts_d, sts_q, sts_d;

  assign rts_d = fifo_count >= RtsLevel;
  assign sts_d = connected;
  assign RTS   = rts_q;
  assign STS   = sts_q;

  always_ff @(posedge CLK) begin
    if (local_rst) begin
      rts_q <= 1'b1;
      sts_q <= 1'b0;
    end else begin
      rts_q <= rts_d;
      sts_q <= sts_d;
    end
  end

endmodule

// File: tb/tb_pmod_bt2_device.sv
// Directed bench for pmod_bt2_device at 8 clocks per bit, 4-entry RX FIFO.
module tb_pmod_bt2_device;

  logic       CLK = 1'b0;
  logic       RST, RXD, TXD, CTS, RTS, STS, BT_RST_N, connected;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, frame_err, overrun;

  always #5 CLK = ~CLK;

  pmod_bt2_device #(
    .BAUD(100),
    .CLK_FREQ(800),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .TXD(TXD), .CTS(CTS), .RTS(RTS), .STS(STS),
    .BT_RST_N(BT_RST_N), .connected(connected),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;

  always @(negedge CLK) if (frame_err === 1'b1) fe_cnt++;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, data, start}, sent LSB first
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    int         exp_fe;
  } rx_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called on the first negedge after the accepting edge.
  task automatic tx_frame_check(input logic [9:0] frame, input int cts_rise);
    for (int i = 0; i <= 80; i++) begin
      if (i == cts_rise) CTS = 1'b1;
      if (i < 80) check($sformatf("txd[%0d]", i), TXD, frame[i/8]);
      if (i == 79) check("tx_ready_in_stop", tx_ready, 0);
      if (i == 80) check("tx_ready_after_frame", tx_ready, (cts_rise < 0) ? 1 : 0);
      if (i < 80) @(negedge CLK);
    end
  endtask

  task automatic uart_send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      RXD = f[b];
      repeat (8) @(negedge CLK);
    end
    RXD = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, rx_valid, 1);
    check(name, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
  endtask

  tx_vec_t tx_tab [2];
  rx_vec_t rx_tab [3];
  int      fe_before;

  initial begin
    tx_tab[0] = '{8'hA5, 10'b1_10100101_0};
    tx_tab[1] = '{8'h3C, 10'b1_00111100_0};
    rx_tab[0] = '{8'h55, 1'b0, 1'b0, 1};
    rx_tab[1] = '{8'h96, 1'b1, 1'b1, 0};
    rx_tab[2] = '{8'hC3, 1'b1, 1'b1, 0};

    RST = 1'b1; RXD = 1'b1; CTS = 1'b0; BT_RST_N = 1'b1; connected = 1'b1;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;

    // 1. Reset values, then idle.
    repeat (3) @(negedge CLK);
    check("rst_txd", TXD, 1);
    check("rst_rts", RTS, 1);
    check("rst_sts", STS, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    check("idle_txd", TXD, 1);
    check("idle_rts", RTS, 0);
    check("idle_tx_ready", tx_ready, 1);
    check("idle_rx_valid", rx_valid, 0);
    check("idle_sts", STS, 1);

    // 2. Back-to-back transmits from the table.
    for (int v = 0; v < 2; v++) begin
      tx_data  = tx_tab[v].data;
      tx_valid = 1'b1;
      @(negedge CLK);
      tx_valid = 1'b0;
      tx_frame_check(tx_tab[v].frame, -1);
    end

    // 3. CTS gating; CTS rising mid-frame does not stop it.
    CTS = 1'b1;
    repeat (3) @(negedge CLK);
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("cts_block_txd", TXD, 1);
      check("cts_block_ready", tx_ready, 0);
    end
    CTS = 1'b0;
    @(negedge CLK);
    check("cts_lat1_txd", TXD, 1);
    @(negedge CLK);
    check("cts_lat2_txd", TXD, 1);
    check("cts_lat2_ready", tx_ready, 1);
    @(negedge CLK);
    tx_valid = 1'b0;
    tx_frame_check(10'b1_00001111_0, 20);
    CTS = 1'b0;
    repeat (3) @(negedge CLK);

    // 4. Fill RX FIFO, RTS threshold, overrun.
    uart_send(8'h3C, 1'b1); repeat (2) @(negedge CLK);
    check("rx1_valid", rx_valid, 1);
    check("rx1_head", rx_data, 8'h3C);
    check("rx1_rts", RTS, 0);
    uart_send(8'h00, 1'b1); repeat (2) @(negedge CLK);
    check("rx2_head", rx_data, 8'h3C);
    check("rx2_rts", RTS, 0);
    uart_send(8'hFF, 1'b1); repeat (2) @(negedge CLK);
    check("rx3_rts", RTS, 1);
    uart_send(8'hA0, 1'b1); repeat (2) @(negedge CLK);
    check("rx4_overrun", overrun, 0);
    uart_send(8'h11, 1'b1); repeat (2) @(negedge CLK);
    check("rx5_overrun", overrun, 1);
    pop_check("pop0", 8'h3C);
    pop_check("pop1", 8'h00);
    pop_check("pop2", 8'hFF);
    pop_check("pop3", 8'hA0);
    check("drained_valid", rx_valid, 0);
    repeat (2) @(negedge CLK);
    check("drained_rts", RTS, 0);
    check("overrun_sticky", overrun, 1);

    // 5. Frame error and good frames from the table, then a glitch.
    for (int v = 0; v < 3; v++) begin
      fe_before = fe_cnt;
      uart_send(rx_tab[v].data, rx_tab[v].stop);
      repeat (4) @(negedge CLK);
      check($sformatf("rxtab%0d_fe", v), fe_cnt - fe_before, rx_tab[v].exp_fe);
      check($sformatf("rxtab%0d_valid", v), rx_valid, rx_tab[v].exp_push);
      if (rx_tab[v].exp_push) pop_check($sformatf("rxtab%0d_data", v), rx_tab[v].data);
    end
    fe_before = fe_cnt;
    RXD = 1'b0;
    repeat (2) @(negedge CLK);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    check("glitch_fe", fe_cnt - fe_before, 0);
    check("glitch_valid", rx_valid, 0);
    uart_send(8'h5A, 1'b1); repeat (2) @(negedge CLK);
    pop_check("after_glitch", 8'h5A);

    // STS is a registered copy of connected.
    connected = 1'b0;
    #1 check("sts_registered", STS, 1);
    @(negedge CLK);
    check("sts_follow0", STS, 0);
    connected = 1'b1;
    @(negedge CLK);
    check("sts_follow1", STS, 1);

    // 6. BT_RST_N mid-frame.
    uart_send(8'h77, 1'b1); repeat (2) @(negedge CLK);
    check("pre_btrst_valid", rx_valid, 1);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    repeat (20) @(negedge CLK);
    check("btrst_mid_txd", TXD, 0);
    BT_RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("btrst_txd", TXD, 1);
    check("btrst_rx_valid", rx_valid, 0);
    check("btrst_rts", RTS, 1);
    check("btrst_tx_ready", tx_ready, 0);
    repeat (10) @(negedge CLK);
    check("btrst_hold_rts", RTS, 1);
    check("btrst_hold_txd", TXD, 1);
    BT_RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    check("btrel_rts", RTS, 0);
    check("btrel_tx_ready", tx_ready, 1);
    check("btrel_txd", TXD, 1);

    // Push and pop coincide at full.
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst2_overrun", overrun, 0);
    uart_send(8'h01, 1'b1);
    uart_send(8'h02, 1'b1);
    uart_send(8'h03, 1'b1);
    uart_send(8'h04, 1'b1);
    repeat (2) @(negedge CLK);
    check("full_rts", RTS, 1);
    fork
      uart_send(8'h05, 1'b1);
      begin
        // Stop bit is sampled on the 79th edge after the start bit is driven.
        repeat (78) @(negedge CLK);
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
      end
    join
    repeat (2) @(negedge CLK);
    check("coincide_overrun", overrun, 0);
    check("coincide_rts", RTS, 1);
    pop_check("coin0", 8'h02);
    pop_check("coin1", 8'h03);
    pop_check("coin2", 8'h04);
    pop_check("coin3", 8'h05);
    check("coin_empty", rx_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
